// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: tracks in-flight register writes across the
// post-decode stages, produces the decode stall and one-hot forwarding selects
// for rs/rt, and owns the HI/LO (mult/div) busy countdown.
//
// Handshake: an instruction presented with issue_valid=1 is accepted on a rising
// edge where stall=0; while stall=1 the D-stage holds the same instruction and a
// bubble enters E.
module hazard_ctrl #(
    parameter int STAGES   = 3,
    parameter int REG_AW   = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [REG_AW-1:0]        rs_addr,
    input  logic [REG_AW-1:0]        rt_addr,
    input  logic [TW-1:0]            tuse_rs,
    input  logic [TW-1:0]            tuse_rt,
    input  logic [REG_AW-1:0]        wr_addr,
    input  logic [TW-1:0]            tnew,
    input  logic                     md_start,
    input  logic                     md_kind,
    input  logic                     md_use,
    output logic                     stall,
    output logic [STAGES-1:0]        fwd_rs_hit,
    output logic [STAGES-1:0]        fwd_rt_hit,
    output logic                     md_busy,
    output logic [STAGES*REG_AW-1:0] stage_wr_addr
);

    localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);

    // The busy counter is the md FSM state: zero means idle, anything else busy.
    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
    md_state_e md_state;

    logic [STAGES-1:0]             rec_valid_q, rec_valid_d;
    logic [STAGES-1:0][REG_AW-1:0] rec_addr_q, rec_addr_d;
    logic [STAGES-1:0][TW-1:0]     rec_tnew_q, rec_tnew_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    logic [STAGES-1:0][TW-1:0]     eff_tnew;
    logic [STAGES-1:0]             rs_oh, rt_oh;
    logic [TW-1:0]                 rs_tn, rt_tn;
    logic                          stall_rs, stall_rt;

    // One-hot of the lowest-index valid record writing src; r0 never matches.
    function automatic logic [STAGES-1:0] nearest_match(
        input logic [REG_AW-1:0]             src,
        input logic [STAGES-1:0]             valid,
        input logic [STAGES-1:0][REG_AW-1:0] addr
    );
        logic [STAGES-1:0] oh;
        oh = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (valid[k] && addr[k] == src && src != '0) begin
                oh    = '0;
                oh[k] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Hazard detection: nearest match per source, stall and forward selects.
    always_comb begin
        md_state = (cnt_q != '0) ? MD_BUSY : MD_IDLE;
        md_busy  = (md_state == MD_BUSY);
        for (int k = 0; k < STAGES; k++) begin
            // A record in W is being written back this cycle, so it is always ready.
            eff_tnew[k] = (k == STAGES - 1) ? '0 : rec_tnew_q[k];
        end
        rs_oh = nearest_match(rs_addr, rec_valid_q, rec_addr_q);
        rt_oh = nearest_match(rt_addr, rec_valid_q, rec_addr_q);
        rs_tn = '0;
        rt_tn = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (rs_oh[k]) rs_tn = eff_tnew[k];
            if (rt_oh[k]) rt_tn = eff_tnew[k];
        end
        stall_rs   = issue_valid && (tuse_rs != '1) && (|rs_oh) && (tuse_rs < rs_tn);
        stall_rt   = issue_valid && (tuse_rt != '1) && (|rt_oh) && (tuse_rt < rt_tn);
        stall      = stall_rs || stall_rt || (issue_valid && md_use && md_busy);
        fwd_rs_hit = (issue_valid && rs_tn == '0) ? rs_oh : '0;
        fwd_rt_hit = (issue_valid && rt_tn == '0) ? rt_oh : '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_wr_addr[k*REG_AW +: REG_AW] = rec_addr_q[k];
        end
    end

    // Next record pipeline and busy counter.
    always_comb begin
        rec_valid_d = '0;
        rec_addr_d  = '0;
        rec_tnew_d  = '0;
        for (int k = 1; k < STAGES; k++) begin
            rec_valid_d[k] = rec_valid_q[k-1];
            rec_addr_d[k]  = rec_addr_q[k-1];
            rec_tnew_d[k]  = (rec_tnew_q[k-1] != '0) ? rec_tnew_q[k-1] - TW'(1) : '0;
        end
        // Invalid records carry addr 0 / tnew 0 so stage_wr_addr reads 0 for bubbles.
        if (issue_valid && !stall && wr_addr != '0) begin
            rec_valid_d[0] = 1'b1;
            rec_addr_d[0]  = wr_addr;
            rec_tnew_d[0]  = tnew;
        end
        cnt_d = cnt_q;
        if (issue_valid && md_start && !stall) begin
            cnt_d = md_kind ? DIV_LAT_C : MULT_LAT_C;
        end else if (md_state == MD_BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers; reset wins over any issue or bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_valid_q <= '0;
            rec_addr_q  <= '0;
            rec_tnew_q  <= '0;
            cnt_q       <= '0;
        end else begin
            rec_valid_q <= rec_valid_d;
            rec_addr_q  <= rec_addr_d;
            rec_tnew_q  <= rec_tnew_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of in-flight writes.
module tb_hazard_ctrl;

    localparam int STAGES   = 3;
    localparam int REG_AW   = 5;
    localparam int TW       = 2;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;
    localparam int UNUSED   = (1 << TW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset;
    logic                     issue_valid;
    logic [REG_AW-1:0]        rs_addr, rt_addr, wr_addr;
    logic [TW-1:0]            tuse_rs, tuse_rt, tnew;
    logic                     md_start, md_kind, md_use;
    logic                     stall, md_busy;
    logic [STAGES-1:0]        fwd_rs_hit, fwd_rt_hit;
    logic [STAGES*REG_AW-1:0] stage_wr_addr;

    hazard_ctrl #(
        .STAGES(STAGES), .REG_AW(REG_AW), .TW(TW),
        .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
        .wr_addr(wr_addr), .tnew(tnew), .md_start(md_start), .md_kind(md_kind),
        .md_use(md_use), .stall(stall), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
        .md_busy(md_busy), .stage_wr_addr(stage_wr_addr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: which instruction sits in each post-D stage and what remains of the busy time.
    int m_valid[STAGES];
    int m_addr[STAGES];
    int m_tnew[STAGES];
    int m_busy_left;

    logic               obs_stall;
    logic [STAGES-1:0]  obs_fwd_rs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int find_src(input int src);
        if (src == 0) return -1;
        for (int k = 0; k < STAGES; k++)
            if (m_valid[k] != 0 && m_addr[k] == src) return k;
        return -1;
    endfunction

    function automatic int ready_in(input int k);
        return (k == STAGES - 1) ? 0 : m_tnew[k];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < STAGES; k++) begin
            m_valid[k] = 0; m_addr[k] = 0; m_tnew[k] = 0;
        end
        m_busy_left = 0;
    endtask

    task automatic drv(input int iv, input int rs, input int trs, input int rt, input int trt,
                       input int wr, input int tn, input int ms, input int mk, input int mu);
        issue_valid = iv[0];
        rs_addr = REG_AW'(rs); tuse_rs = TW'(trs);
        rt_addr = REG_AW'(rt); tuse_rt = TW'(trt);
        wr_addr = REG_AW'(wr); tnew = TW'(tn);
        md_start = ms[0]; md_kind = mk[0]; md_use = mu[0];
    endtask

    task automatic nop();
        drv(0, 0, UNUSED, 0, UNUSED, 0, 0, 0, 0, 0);
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        int  kr, kt;
        bit  e_stall;
        logic [STAGES-1:0]        e_frs, e_frt;
        logic [STAGES*REG_AW-1:0] e_sa;
        @(negedge clk);
        kr = find_src(int'(rs_addr));
        kt = find_src(int'(rt_addr));
        e_stall = issue_valid &&
                  ((int'(tuse_rs) != UNUSED && kr >= 0 && int'(tuse_rs) < ready_in(kr)) ||
                   (int'(tuse_rt) != UNUSED && kt >= 0 && int'(tuse_rt) < ready_in(kt)) ||
                   (md_use && m_busy_left > 0));
        e_frs = '0;
        e_frt = '0;
        if (issue_valid && kr >= 0 && ready_in(kr) == 0) e_frs[kr] = 1'b1;
        if (issue_valid && kt >= 0 && ready_in(kt) == 0) e_frt[kt] = 1'b1;
        e_sa = '0;
        for (int k = 0; k < STAGES; k++)
            e_sa[k*REG_AW +: REG_AW] = (m_valid[k] != 0) ? REG_AW'(m_addr[k]) : '0;
        check("stall", 32'(stall), 32'(e_stall));
        check("fwd_rs", 32'(fwd_rs_hit), 32'(e_frs));
        check("fwd_rt", 32'(fwd_rt_hit), 32'(e_frt));
        check("md_busy", 32'(md_busy), 32'(m_busy_left > 0));
        check("stage_wr_addr", 32'(stage_wr_addr), 32'(e_sa));
        obs_stall  = stall;
        obs_fwd_rs = fwd_rs_hit;
        if (reset) begin
            model_clear();
        end else begin
            for (int k = STAGES - 1; k > 0; k--) begin
                m_valid[k] = m_valid[k-1];
                m_addr[k]  = m_addr[k-1];
                m_tnew[k]  = (m_tnew[k-1] > 0) ? m_tnew[k-1] - 1 : 0;
            end
            m_valid[0] = (issue_valid && !e_stall && wr_addr != 0) ? 1 : 0;
            m_addr[0]  = m_valid[0] ? int'(wr_addr) : 0;
            m_tnew[0]  = m_valid[0] ? int'(tnew) : 0;
            if (issue_valid && md_start && !e_stall) m_busy_left = md_kind ? DIV_LAT : MULT_LAT;
            else if (m_busy_left > 0) m_busy_left--;
        end
        @(posedge clk);
        #1;
    endtask

    // Hold the current D instruction until it is accepted; returns cycles stalled.
    task automatic hold_until_issued(output int n_stall);
        n_stall = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!obs_stall) break;
            n_stall++;
        end
    endtask

    task automatic quiet(input int n);
        nop();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int ns;
        reset = 1'b1;
        drv($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 31),
            $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3), 1, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        reset = 1'b0;
        nop();
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_fwd", 32'({fwd_rs_hit, fwd_rt_hit}), 32'd0);
        check("rst_stage_addr", 32'(stage_wr_addr), 32'd0);
        @(posedge clk);
        #1;

        // Load-use: lw r8 (tnew 2) followed by add using r8 one cycle later.
        drv(1, 0, UNUSED, 0, UNUSED, 8, 2, 0, 0, 0); step();
        drv(1, 8, 1, 0, 1, 9, 1, 0, 0, 0);
        hold_until_issued(ns);
        check("load_use_stalls", 32'(ns), 32'd1);
        check("load_use_fwd", 32'(obs_fwd_rs), 32'd0);
        quiet(3);

        // Branch after load: needs r8 immediately, waits until W forwards it.
        drv(1, 0, UNUSED, 0, UNUSED, 8, 2, 0, 0, 0); step();
        drv(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        hold_until_issued(ns);
        check("branch_stalls", 32'(ns), 32'd2);
        check("branch_fwd", 32'(obs_fwd_rs), 32'b100);
        quiet(3);

        // Nearest producer wins; r0 never forwards.
        drv(1, 0, UNUSED, 0, UNUSED, 5, 0, 0, 0, 0); step();
        drv(1, 0, UNUSED, 0, UNUSED, 5, 0, 0, 0, 0); step();
        drv(1, 5, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check("priority_fwd", 32'(obs_fwd_rs), 32'b001);
        drv(1, 0, UNUSED, 0, UNUSED, 0, 3, 0, 0, 0); step();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check("r0_no_stall", 32'(obs_stall), 32'd0);
        quiet(3);

        // div, plain add while busy, then mfhi at busy cycle 5.
        drv(1, 0, UNUSED, 0, UNUSED, 0, 0, 1, 1, 1); step();
        drv(1, 3, 1, 4, 1, 6, 1, 0, 0, 0); step();
        check("add_during_busy", 32'(obs_stall), 32'd0);
        quiet(3);
        drv(1, 0, UNUSED, 0, UNUSED, 7, 1, 0, 0, 1);
        hold_until_issued(ns);
        check("mfhi_stalls", 32'(ns), 32'd6);
        quiet(2);

        // Reset in the middle of a div clears the busy count.
        drv(1, 0, UNUSED, 0, UNUSED, 0, 0, 1, 1, 1); step();
        quiet(3);
        reset = 1'b1; step(); reset = 1'b0;
        drv(1, 0, UNUSED, 0, UNUSED, 7, 1, 0, 0, 1);
        hold_until_issued(ns);
        check("mfhi_after_reset", 32'(ns), 32'd0);
        quiet(2);

        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            int ms;
            ms = ($urandom_range(0, 9) == 0) ? 1 : 0;
            reset = ($urandom_range(0, 63) == 0);
            drv(($urandom_range(0, 4) != 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), ms, $urandom_range(0, 1),
                (ms == 1 || $urandom_range(0, 7) == 0) ? 1 : 0);
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised decode-stage hazard controller for the pipelined MIPS core. It replaces externally supplied per-stage destination/Tnew inputs with an internal shift register of in-flight write records across STAGES post-decode stages. From those records it generates the stall and one-hot forwarding selects for rs and rt. It also owns the mult/div busy countdown and stalls HI/LO users while the countdown runs.

Parameters:
STAGES, 3, number of tracked post-D stages (index 0 = E, STAGES-1 = W)
REG_AW, 5, register address width
TW, 2, Tuse/Tnew width; all-ones Tuse = "operand not used"
MULT_LAT, 5, mult/multu busy cycles
DIV_LAT, 10, div/divu busy cycles
CNT_W, 4, busy counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  D-stage instruction valid
rs_addr  in  REG_AW  D-stage rs
rt_addr  in  REG_AW  D-stage rt
tuse_rs  in  TW  cycles until rs needed; all-ones = unused
tuse_rt  in  TW  cycles until rt needed; all-ones = unused
wr_addr  in  REG_AW  destination; 0 = no write
tnew  in  TW  Tnew the instruction will have on entering E
md_start  in  1  D instruction is mult/multu/div/divu
md_kind  in  1  0 = mult class, 1 = div class
md_use  in  1  D instruction touches HI/LO (md, mfhi, mflo, mthi, mtlo)
stall  out  1  freeze PC and F/D; insert a bubble into E
fwd_rs_hit  out  STAGES  one-hot forwarding source for rs; 0 = register file
fwd_rt_hit  out  STAGES  one-hot forwarding source for rt; 0 = register file
md_busy  out  1  HI/LO unit busy
stage_wr_addr  out  STAGES*REG_AW  flattened record addresses; stage k at [k*REG_AW +: REG_AW]; 0 when invalid

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset. Reset takes priority over every other event.
- Reset values:
  - All records are invalid: addr 0, tnew 0.
  - Busy counter is 0, so md_busy = 0.
  - stall, fwd_rs_hit and fwd_rt_hit evaluate to 0.
- Record k holds valid, addr and tnew.
- Record update, every cycle when reset is low:
  - rec[k] <= rec[k-1] with tnew saturating-decremented (tnew - 1, floor 0).
  - rec[0] <= {1, wr_addr, tnew} when issue_valid and not stall and wr_addr != 0; otherwise rec[0] <= invalid (bubble).
- Last stage (W): forwarding logic treats its tnew as 0.
- Match for source s (rs or rt) at stage k: rec[k].valid and rec[k].addr == s and s != 0. Only the nearest match, i.e. the lowest k, is considered.
- stall_s = issue_valid and tuse_s != all-ones and a nearest match exists and tuse_s < rec[k].tnew.
- stall = stall_rs | stall_rt | (issue_valid & md_use & md_busy). It is combinational from the records, the counter and the inputs.
- fwd_s_hit: bit k is set iff issue_valid and the nearest match is at stage k with effective tnew == 0; all zeros otherwise. It is at most one-hot and is independent of stall.
- A nearest match with 0 < tnew <= tuse gives no stall and fwd = 0. Later-stage forwarding resolves that case.
- MD counter (states IDLE: cnt == 0; BUSY: cnt != 0):
  - On issue_valid & md_start & !stall, cnt <= md_kind ? DIV_LAT : MULT_LAT.
  - Otherwise, if cnt != 0, cnt <= cnt - 1.
  - md_busy = (cnt != 0). It goes high the cycle after acceptance, while the md instruction is in E, and stays high for exactly LAT cycles.
  - A latency of 0 never asserts busy.
- A HI/LO user presented while cnt == 1 still stalls; it is accepted on the next cycle.
- A second md_start is never accepted while busy, because md_use must be set for md instructions.
- Reset during BUSY clears cnt, so md_busy = 0 on the next cycle.
- Reset with stall active clears all records; no bubble or issue is recorded.

Test Plan:
- Reset: hold reset 2 cycles with random inputs, then drop it -> stall=0, md_busy=0, fwd hits=0, stage_wr_addr=0.
- Load-use: issue lw wr=8 tnew=2, then add rs=8 tuse_rs=1 -> stall=1 for 1 cycle, then add issues with fwd_rs_hit=000 (rec at M, tnew 1).
- Branch after load: issue lw wr=8 tnew=2, then beq rs=8 tuse=0 -> stall 2 cycles, then fwd_rs_hit=100 (W).
- Priority and r0: E record r5 tnew 0 and M record r5 tnew 0 -> fwd_rs_hit=001; sources using r0, or wr_addr=0, -> never stall or forward.
- MD: DIV_LAT=10, issue div -> md_busy high exactly 10 cycles. mfhi presented at cycle 5 -> stall until busy falls, accepted on the first cycle with md_busy=0. Plain add (md_use=0) during busy -> no stall.
- Reset mid-div at busy cycle 4 -> md_busy=0 on the next cycle; mfhi then issues with stall=0.
